// File: rtl/anim_timer_pkg.sv
// Shared types and mode constants for the multi-channel animation interval timer.
package anim_timer_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE} anim_tmr_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/anim_timer_ch.sv
// One timer channel: a state machine plus a tick counter. Limit and mode are captured when the channel starts.
import anim_timer_pkg::*;

module anim_timer_ch #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             done_pulse
);
    anim_tmr_state_t state_q, state_n;
    logic [CNT_W-1:0] count_q, count_n, lim_q, lim_n;
    logic             mode_q, mode_n, pulse_q, pulse_n;
    logic [CNT_W:0]   inc;

    // The extra bit keeps a limit of all-ones from wrapping during the compare.
    assign inc = {1'b0, count_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            lim_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            lim_q   <= lim_n;
            mode_q  <= mode_n;
            pulse_q <= pulse_n;
        end
    end

    always_comb begin
        state_n = state_q;
        count_n = count_q;
        lim_n   = lim_q;
        mode_n  = mode_q;
        pulse_n = 1'b0;
        if (!en || stop) begin
            state_n = ST_IDLE;
            count_n = '0;
        end else if (start) begin
            count_n = '0;
            lim_n   = limit;
            mode_n  = periodic;
            if (limit == '0) begin
                pulse_n = 1'b1;
                state_n = (periodic == MODE_ONESHOT) ? ST_DONE : ST_RUN;
            end else begin
                state_n = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end else if (tick) begin
                        // ">=" also covers a periodic channel with a zero limit: it pulses every tick.
                        if (inc >= {1'b0, lim_q}) begin
                            pulse_n = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                count_n = '0;
                            end else begin
                                count_n = lim_q;
                                state_n = ST_DONE;
                            end
                        end else begin
                            count_n = inc[CNT_W-1:0];
                        end
                    end
                end
                ST_PAUSED: if (!pause) state_n = ST_RUN;
                default: ;
            endcase
        end
    end

    assign count      = count_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign done       = (state_q == ST_DONE);
    assign done_pulse = pulse_q;
endmodule

// File: rtl/anim_interval_timer.sv
// Shared base-tick prescaler feeding NUM_CH independent interval timer channels.
import anim_timer_pkg::*;

module anim_interval_timer #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 100000000,
    parameter int PRE_W    = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       pause,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] limit,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       done_pulse
);
    logic [PRE_W-1:0] pre;
    logic             tick;

    // Free-running while enabled; start does not re-phase it.
    assign tick = en && (pre == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pre <= '0;
        else if (!en || tick) pre <= '0;
        else                 pre <= pre + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        anim_timer_ch #(.CNT_W(CNT_W)) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .tick       (tick),
            .start      (start[i]),
            .stop       (stop[i]),
            .pause      (pause[i]),
            .periodic   (periodic[i]),
            .limit      (limit[i*CNT_W +: CNT_W]),
            .count      (count[i*CNT_W +: CNT_W]),
            .busy       (busy[i]),
            .done       (done[i]),
            .done_pulse (done_pulse[i])
        );
    end
endmodule

// File: tb/tb_anim_interval_timer.sv
// Directed bench for anim_interval_timer with a done_pulse scoreboard keyed by channel and cycle.
module tb_anim_interval_timer;
    localparam int NUM_CH = 2, CNT_W = 4, TICK_DIV = 4, PRE_W = 2;

    logic                    clk = 1'b0, rst_n, en;
    logic [NUM_CH-1:0]       start, stop, pause, periodic;
    logic [NUM_CH*CNT_W-1:0] limit, count;
    logic [NUM_CH-1:0]       busy, done, done_pulse;

    anim_interval_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .limit(limit), .count(count), .busy(busy), .done(done),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int cyc; } exp_t;
    exp_t sbq[$];
    int   vectors = 0, miscompares = 0, cyc = 0, bpre = 0, s;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference prescaler phase: when it reads TICK_DIV-1 after an edge, the next edge is a tick.
    always @(posedge clk or negedge rst_n)
        if (!rst_n)                 bpre <= 0;
        else if (!en)               bpre <= 0;
        else if (bpre == TICK_DIV-1) bpre <= 0;
        else                        bpre <= bpre + 1;

    always @(negedge clk) begin
        int idx;
        for (int c = 0; c < NUM_CH; c++) begin
            if (done_pulse[c]) begin
                idx = -1;
                foreach (sbq[i]) if (idx < 0 && sbq[i].ch == c && sbq[i].cyc == cyc) idx = i;
                vectors++;
                assert (idx >= 0) else begin
                    miscompares++;
                    $error("FAIL pulse_ch%0d: observed pulse at cycle %0d, expected none there", c, cyc);
                end
                if (idx >= 0) sbq.delete(idx);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        int n = 0;
        while (bpre != TICK_DIV-1 && n < 16) begin step(1); n++; end
    endtask

    // Start a channel one cycle ahead of a tick edge; s receives the cycle number of the start edge.
    task automatic go(input int ch, input int lim, input logic per);
        align();
        limit[ch*CNT_W +: CNT_W] = CNT_W'(lim);
        periodic[ch] = per;
        start[ch] = 1'b1;
        step(1);
        start[ch] = 1'b0;
        s = cyc;
    endtask

    task automatic halt(input int ch);
        stop[ch] = 1'b1; step(1); stop[ch] = 1'b0;
    endtask

    function automatic logic [CNT_W-1:0] cnt(input int ch);
        return count[ch*CNT_W +: CNT_W];
    endfunction

    initial begin
        rst_n = 1'b1; en = 1'b0;
        start = '0; stop = '0; pause = '0; periodic = '0; limit = '0;
        #2 rst_n = 1'b0;
        step(2);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pulse", done_pulse, 0);
        rst_n = 1'b1; en = 1'b1;
        step(1);

        // One-shot, limit 10; start lands on a tick edge, which is not counted.
        go(0, 10, 1'b0);
        sbq.push_back('{0, s + 40});
        chk("os_start_cnt", cnt(0), 0);
        chk("os_start_busy", busy[0], 1);
        for (int k = 1; k <= 10; k++) begin
            step(4);
            chk($sformatf("os_cnt%0d", k), cnt(0), k);
            chk($sformatf("os_done%0d", k), done[0], (k == 10));
        end
        step(5);
        chk("os_hold_cnt", cnt(0), 10);
        chk("os_hold_done", done[0], 1);
        halt(0);
        chk("os_stop_done", done[0], 0);
        chk("os_stop_cnt", cnt(0), 0);

        // Periodic, limit 3 on ch1.
        go(1, 3, 1'b1);
        sbq.push_back('{1, s + 12});
        sbq.push_back('{1, s + 24});
        for (int k = 1; k <= 6; k++) begin
            step(4);
            chk($sformatf("per_cnt%0d", k), cnt(1), k % 3);
            chk($sformatf("per_done%0d", k), done[1], 0);
        end
        halt(1);
        chk("per_stop_busy", busy[1], 0);

        // Pause at count 4 across three ticks; done arrives three ticks late.
        go(0, 8, 1'b0);
        sbq.push_back('{0, s + 44});
        step(16);
        chk("pz_pre_cnt", cnt(0), 4);
        pause[0] = 1'b1;
        step(12);
        chk("pz_held_cnt", cnt(0), 4);
        chk("pz_busy", busy[0], 1);
        pause[0] = 1'b0;
        step(1);
        chk("pz_resume_cnt", cnt(0), 4);
        step(14);
        chk("pz_not_yet", done[0], 0);
        step(1);
        chk("pz_done", done[0], 1);
        chk("pz_done_cnt", cnt(0), 8);

        // Stop and start together: stop wins.
        limit[3:0] = 4'd5; start[0] = 1'b1; stop[0] = 1'b1;
        step(1);
        start[0] = 1'b0; stop[0] = 1'b0;
        chk("ss_busy", busy[0], 0);
        chk("ss_done", done[0], 0);
        chk("ss_cnt", cnt(0), 0);

        // Global enable drop while running.
        go(0, 10, 1'b0);
        step(8);
        chk("en_pre_cnt", cnt(0), 2);
        en = 1'b0;
        step(1);
        en = 1'b1;
        chk("en_busy", busy[0], 0);
        chk("en_cnt", cnt(0), 0);

        // Zero limit one-shot: pulse the very next clock.
        limit[3:0] = 4'd0; periodic[0] = 1'b0; start[0] = 1'b1;
        sbq.push_back('{0, cyc + 1});
        step(1);
        start[0] = 1'b0;
        chk("z_pulse", done_pulse[0], 1);
        chk("z_done", done[0], 1);
        chk("z_cnt", cnt(0), 0);
        step(1);
        chk("z_pulse_once", done_pulse[0], 0);
        halt(0);

        // Full-scale limit does not wrap.
        go(0, 15, 1'b0);
        sbq.push_back('{0, s + 60});
        step(56);
        chk("max_cnt14", cnt(0), 14);
        step(4);
        chk("max_cnt15", cnt(0), 15);
        chk("max_done", done[0], 1);
        step(8);
        chk("max_hold", cnt(0), 15);
        halt(0);

        // Reset mid-run clears outputs asynchronously and re-phases the prescaler.
        go(0, 10, 1'b0);
        step(12);
        chk("mr_pre_cnt", cnt(0), 3);
        rst_n = 1'b0;
        #2;
        chk("mr_cnt", count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        go(0, 2, 1'b0);
        sbq.push_back('{0, s + 8});
        step(8);
        chk("mr_after_done", done[0], 1);
        halt(0);

        step(4);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
